// File: rtl/intra4x4_block_feeder.sv
// ----------------------------------------------------------------------------
// intra4x4_block_feeder
//
// Collects raster-ordered luma macroblocks (16x16 pixels, 64 words of 4 pixels)
// into a pair of ping-pong buffers and replays each complete macroblock to an
// intra4x4 predictor as 64 consecutive 4x4 sub-block rows in H.264 luma order.
//
// Ports
//   CLK      in   1  rising-edge clock
//   RESETN   in   1  synchronous, active-low reset
//   WSTROBE  in   1  raster write strobe, one word per cycle
//   WDATA    in  32  4 pixels of a macroblock row segment, leftmost in [31:24]
//   WREADY   out  1  fill buffer has room
//   READYI   in   1  predictor can accept a whole macroblock
//   STROBEO  out  1  DATAO valid
//   DATAO    out 32  one 4x4 sub-block row
//   LASTO    out  1  marks the 64th word of a burst
//   BUFCNT   out  2  number of full macroblock buffers (0..2)
//
// Handshakes
//   Write side: a word transfers on a rising edge where WSTROBE=1 and
//   WREADY=1; WSTROBE while WREADY=0 is dropped. Read side: READYI is a
//   per-macroblock grant sampled only in IDLE; once a burst starts it runs
//   64 cycles without back-pressure, STROBEO qualifies every word.
//
// The drain FSM state is visible as the internal signal drain_state.
// ----------------------------------------------------------------------------
module intra4x4_block_feeder (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        WSTROBE,
    input  logic [31:0] WDATA,
    output logic        WREADY,
    input  logic        READYI,
    output logic        STROBEO,
    output logic [31:0] DATAO,
    output logic        LASTO,
    output logic [1:0]  BUFCNT
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } drain_state_t;

    drain_state_t drain_state;

    // Buffer b occupies mem[{b, addr}], addr being the 6-bit raster index.
    logic [31:0] mem [0:127];

    logic [1:0] full;
    logic       fill_ptr;
    logic       drain_ptr;
    logic [5:0] w_idx;
    logic [5:0] n_idx;

    logic       wr_en;
    logic       fill_done;
    logic       burst_start;
    logic       drain_done;
    logic [5:0] rd_addr;

    assign WREADY = ~full[fill_ptr];
    assign BUFCNT = {1'b0, full[0]} + {1'b0, full[1]};

    // Writes are also blocked while reset is asserted.
    assign wr_en       = WSTROBE & WREADY & RESETN;
    assign fill_done   = wr_en && (w_idx == 6'd63);
    assign burst_start = (drain_state == ST_IDLE) && READYI && full[drain_ptr];
    assign drain_done  = (drain_state == ST_BURST) && (n_idx == 6'd63);

    // n = {b3,b2,b1,b0,r1,r0}: sub-block b in 8x8-quadrant order, row r.
    // Raster address = {row[3:0], col[1:0]} with row = {b3,b1,r1,r0} and
    // col = {b2,b0}.
    assign rd_addr = {n_idx[5], n_idx[3], n_idx[1], n_idx[0], n_idx[4], n_idx[2]};

    // Buffer storage carries no reset. The fill buffer is never full while
    // being written and the drain buffer always is, so a write and a read
    // in the same cycle always target different halves.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[{fill_ptr, w_idx}] <= WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            full        <= 2'b00;
            fill_ptr    <= 1'b0;
            drain_ptr   <= 1'b0;
            w_idx       <= 6'd0;
            n_idx       <= 6'd0;
            drain_state <= ST_IDLE;
            STROBEO     <= 1'b0;
            LASTO       <= 1'b0;
            DATAO       <= 32'd0;
        end else begin
            // Fill side
            if (wr_en) begin
                w_idx <= w_idx + 6'd1;
            end
            if (fill_done) begin
                fill_ptr <= ~fill_ptr;
            end

            // The set and clear always address different buffers, so the
            // two flag updates never collide.
            if (fill_done) begin
                full[fill_ptr] <= 1'b1;
            end
            if (drain_done) begin
                full[drain_ptr] <= 1'b0;
            end

            // Drain side
            case (drain_state)
                ST_IDLE: begin
                    STROBEO <= 1'b0;
                    LASTO   <= 1'b0;
                    if (burst_start) begin
                        n_idx       <= 6'd0;
                        drain_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    STROBEO <= 1'b1;
                    DATAO   <= mem[{drain_ptr, rd_addr}];
                    LASTO   <= (n_idx == 6'd63);
                    n_idx   <= n_idx + 6'd1;
                    if (drain_done) begin
                        drain_ptr   <= ~drain_ptr;
                        drain_state <= ST_IDLE;
                    end
                end
                default: begin
                    STROBEO     <= 1'b0;
                    LASTO       <= 1'b0;
                    drain_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intra4x4_block_feeder.sv
// ----------------------------------------------------------------------------
// tb_intra4x4_block_feeder
//
// Directed bench for intra4x4_block_feeder. Each macroblock written is turned
// into its 64 expected output words (with the LASTO bit) in sub-block order
// and queued; a negedge monitor pops and compares every STROBEO word and
// checks that bursts are unbroken and separated by an idle cycle.
// ----------------------------------------------------------------------------
module tb_intra4x4_block_feeder;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        CLK = 1'b0;
    logic        RESETN;
    logic        WSTROBE;
    logic [31:0] WDATA;
    logic        WREADY;
    logic        READYI;
    logic        STROBEO;
    logic [31:0] DATAO;
    logic        LASTO;
    logic [1:0]  BUFCNT;

    always #5 CLK = ~CLK;

    intra4x4_block_feeder dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .WSTROBE (WSTROBE),
        .WDATA   (WDATA),
        .WREADY  (WREADY),
        .READYI  (READYI),
        .STROBEO (STROBEO),
        .DATAO   (DATAO),
        .LASTO   (LASTO),
        .BUFCNT  (BUFCNT)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] obs_log[$];
    logic [31:0] cur_mb[64];
    int          strobe_cnt  = 0;
    int          wready_low  = 0;
    int          strobe_snap = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_last   = 1'b0;
    logic [32:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Raster address of output word n (n = {b[3:0], r[1:0]}).
    function automatic logic [5:0] raster_of(input logic [5:0] n);
        logic [3:0] b;
        logic [1:0] r;
        b = n[5:2];
        r = n[1:0];
        return {b[3], b[1], r, b[2], b[0]};
    endfunction

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        if (RESETN === 1'b1 && prev_strobe && !prev_last)
            check("burst_contiguous", 64'(STROBEO), 64'(1));
        if (prev_last)
            check("burst_gap", 64'(STROBEO), 64'(0));
        if (prev_strobe && STROBEO !== 1'b1)
            check("lasto_idle", 64'(LASTO), 64'(0));
        if (STROBEO === 1'b1) begin
            strobe_cnt++;
            obs_log.push_back(DATAO);
            if (exp_q.size() == 0) begin
                check("spurious_word", 64'(STROBEO), 64'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", 64'({LASTO, DATAO}), 64'(mon_exp));
            end
        end
        prev_strobe = (STROBEO === 1'b1);
        prev_last   = (LASTO === 1'b1);
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        WSTROBE = 1'b1;
        WDATA   = d;
        tick();
        WSTROBE = 1'b0;
    endtask

    // mode 0: word w carries value w; otherwise random contents.
    task automatic gen_mb(input int mode);
        for (int i = 0; i < 64; i++)
            cur_mb[i] = (mode == 0) ? 32'(i) : $urandom();
    endtask

    task automatic write_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (WREADY !== 1'b1) wready_low++;
            write_word(cur_mb[i]);
        end
    endtask

    task automatic push_expected();
        for (int n = 0; n < 64; n++)
            exp_q.push_back({(n == 63), cur_mb[raster_of(6'(n))]});
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || STROBEO === 1'b1) && k < 2000) begin
            tick();
            k++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        // Reset for 3 cycles with writes attempted (must be ignored)
        RESETN  = 1'b0;
        WSTROBE = 1'b1;
        WDATA   = 32'hA5A5_A5A5;
        READYI  = 1'b1;
        repeat (3) tick();
        check("rst_strobeo", 64'(STROBEO), 64'(0));
        check("rst_lasto",   64'(LASTO),   64'(0));
        check("rst_datao",   64'(DATAO),   64'(0));
        check("rst_wready",  64'(WREADY),  64'(1));
        check("rst_bufcnt",  64'(BUFCNT),  64'(0));
        RESETN  = 1'b1;
        WSTROBE = 1'b0;
        tick();
        check("idle_strobeo", 64'(STROBEO), 64'(0));

        // Single macroblock, WDATA = w
        obs_log.delete();
        gen_mb(0);
        write_range(0, 63);
        push_expected();
        check("single_bufcnt_full", 64'(BUFCNT), 64'(1));
        wait_drain("single_drain");
        check("single_count", 64'(obs_log.size()), 64'(64));
        if (obs_log.size() == 64) begin
            check("single_w0",  64'(obs_log[0]),  64'(0));
            check("single_w1",  64'(obs_log[1]),  64'(4));
            check("single_w3",  64'(obs_log[3]),  64'(12));
            check("single_w4",  64'(obs_log[4]),  64'(1));
            check("single_w8",  64'(obs_log[8]),  64'(16));
            check("single_w16", 64'(obs_log[16]), 64'(2));
            check("single_w63", 64'(obs_log[63]), 64'(63));
        end
        check("single_bufcnt_empty", 64'(BUFCNT), 64'(0));

        // Overlap + simultaneous completion
        wready_low = 0;
        gen_mb(1);
        write_range(0, 63);
        push_expected();
        tick();                     // one idle cycle lines MB1's last write up with MB0's LASTO
        gen_mb(1);
        write_range(0, 62);
        check("sim_bufcnt_before", 64'(BUFCNT), 64'(1));
        check("sim_strobe_before", 64'(STROBEO), 64'(1));
        write_range(63, 63);
        check("sim_lasto",        64'(LASTO),  64'(1));
        check("sim_bufcnt_after", 64'(BUFCNT), 64'(1));
        push_expected();
        check("overlap_wready", 64'(wready_low), 64'(0));
        wait_drain("overlap_drain");
        check("overlap_bufcnt", 64'(BUFCNT), 64'(0));

        // Back-pressure: two macroblocks held while READYI=0
        READYI      = 1'b0;
        strobe_snap = strobe_cnt;
        wready_low  = 0;
        gen_mb(1);
        write_range(0, 63);
        push_expected();
        gen_mb(1);
        write_range(0, 63);
        push_expected();
        check("bp_wready_during", 64'(wready_low), 64'(0));
        check("bp_bufcnt",  64'(BUFCNT), 64'(2));
        check("bp_wready",  64'(WREADY), 64'(0));
        write_word(32'hDEAD_BEEF);  // 129th write, must be dropped
        repeat (4) tick();
        check("bp_bufcnt_hold", 64'(BUFCNT), 64'(2));
        check("bp_no_strobe", 64'(strobe_cnt - strobe_snap), 64'(0));
        READYI = 1'b1;
        wait_drain("bp_drain");
        check("bp_word_count", 64'(strobe_cnt - strobe_snap), 64'(128));
        check("bp_bufcnt_empty", 64'(BUFCNT), 64'(0));

        // Mid-burst reset at word 20
        obs_log.delete();
        gen_mb(1);
        write_range(0, 63);
        push_expected();
        repeat (21) tick();         // word 19 registered on the last of these edges
        RESETN = 1'b0;
        tick();
        check("abort_strobeo", 64'(STROBEO), 64'(0));
        check("abort_bufcnt",  64'(BUFCNT),  64'(0));
        check("abort_wready",  64'(WREADY),  64'(1));
        check("abort_words",   64'(obs_log.size()), 64'(20));
        tick();
        check("abort_datao", 64'(DATAO), 64'(0));
        exp_q.delete();
        RESETN = 1'b1;
        tick();

        // Fresh macroblock after the abort
        obs_log.delete();
        gen_mb(1);
        write_range(0, 63);
        push_expected();
        wait_drain("post_reset_drain");
        check("post_reset_count", 64'(obs_log.size()), 64'(64));
        if (obs_log.size() == 64)
            check("post_reset_w0", 64'(obs_log[0]), 64'(cur_mb[0]));
        check("post_reset_bufcnt", 64'(BUFCNT), 64'(0));

        repeat (3) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
